// File: rtl/jk_pkg.sv
// Shared types for the JK excitation generator: FSM states and {j,k} encodings.
package jk_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } jk_state_e;

  typedef logic [1:0] jk_exc_t;  // {j, k}

  localparam jk_exc_t JK_HOLD   = 2'b00;
  localparam jk_exc_t JK_RESET  = 2'b01;
  localparam jk_exc_t JK_SET    = 2'b10;
  localparam jk_exc_t JK_TOGGLE = 2'b11;

  localparam int CNT_W = 4;

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit (shadow q, target t) -> {j,k} excitation.
// JK_TOGGLE_PREF_EN selects toggle encoding for changing bits instead of set/reset.
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic q_i,
  input  logic t_i,
  output logic j_o,
  output logic k_o
);

  jk_exc_t exc;

  always_comb begin
    exc = JK_HOLD;
`ifdef JK_TOGGLE_PREF_EN
    if (q_i != t_i) exc = JK_TOGGLE;
`else
    unique case ({q_i, t_i})
      2'b01:   exc = JK_SET;
      2'b10:   exc = JK_RESET;
      default: exc = JK_HOLD;
    endcase
`endif
  end

  assign {j_o, k_o} = exc;

endmodule

// File: rtl/jk_excite_gen.sv
// JK latch bank driver: accepts a target word, pulses excitation, settles, reads back.
// Optional JK_TOGGLE_PREF_EN (in jk_excite_bit) drives changing bits with J=K=1.
//   state  | meaning
//   INIT   | after reset: one idle cycle, then one clear pulse (K=all ones, latch_en=1)
//   IDLE   | in_ready high, waiting for a target word
//   DRIVE  | excitation on j/k with latch_en high for one cycle
//   SETTLE | J=K=0, counting SETTLE_CYC cycles down
//   CHECK  | done pulse; mismatch, shadow and err_cnt updated from readback
module jk_excite_gen
  import jk_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 1,
  parameter int ERRW       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             latch_en,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             mismatch,
  output logic [ERRW-1:0]  err_cnt
);

  jk_state_e        state_q;
  logic             init_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] tgt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ERRW-1:0]  err_q;
  logic [WIDTH-1:0] j_q, k_q;
  logic             le_q, rdy_q, done_q, mm_q;
  logic [WIDTH-1:0] j_d, k_d;

  // Excitation is computed from the incoming word so DRIVE outputs can be registered at acceptance.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    jk_excite_bit u_bit (
      .q_i (shadow_q[b]),
      .t_i (in_data[b]),
      .j_o (j_d[b]),
      .k_o (k_d[b])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= INIT;
      init_q   <= 1'b0;
      shadow_q <= '0;
      tgt_q    <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      le_q     <= 1'b0;
      rdy_q    <= 1'b0;
      done_q   <= 1'b0;
      mm_q     <= 1'b0;
    end else begin
      j_q    <= '0;
      k_q    <= '0;
      le_q   <= 1'b0;
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
      mm_q   <= 1'b0;
      unique case (state_q)
        INIT: begin
          shadow_q <= '0;
          if (!init_q) begin
            init_q <= 1'b1;
            k_q    <= '1;
            le_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end
        end
        IDLE: begin
          if (in_valid && rdy_q) begin
            tgt_q   <= in_data;
            j_q     <= j_d;
            k_q     <= k_d;
            le_q    <= 1'b1;
            state_q <= DRIVE;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        DRIVE: begin
          cnt_q   <= CNT_W'(SETTLE_CYC - 1);
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_q  <= CHECK;
            done_q   <= 1'b1;
            mm_q     <= (q_fb != tgt_q);
            shadow_q <= q_fb;  // resync to the real bank, not the intended value
            if ((q_fb != tgt_q) && (err_q != {ERRW{1'b1}}))
              err_q <= err_q + ERRW'(1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        CHECK: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign in_ready = rdy_q;
  assign j_out    = j_q;
  assign k_out    = k_q;
  assign latch_en = le_q;
  assign done     = done_q;
  assign mismatch = mm_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_jk_excite_gen.sv
// Directed bench for jk_excite_gen with a behavioural JK latch bank model.
module tb_jk_excite_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'b0000;
  logic [3:0] j_out, k_out, q_fb;
  logic       latch_en, done, mismatch;
  logic [7:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [3:0] bank_q = 4'b0110;
  logic       stuck = 1'b0;

`ifdef JK_TOGGLE_PREF_EN
  localparam logic [3:0] EJ_BASIC = 4'b1010, EK_BASIC = 4'b1010;
  localparam logic [3:0] EJ_MIXED = 4'b1100, EK_MIXED = 4'b1100;
  localparam logic [3:0] EJ_F1    = 4'b0111, EK_F1    = 4'b0111;
  localparam logic [3:0] EJ_F2    = 4'b0001, EK_F2    = 4'b0001;
`else
  localparam logic [3:0] EJ_BASIC = 4'b1010, EK_BASIC = 4'b0000;
  localparam logic [3:0] EJ_MIXED = 4'b0100, EK_MIXED = 4'b1000;
  localparam logic [3:0] EJ_F1    = 4'b0001, EK_F1    = 4'b0110;
  localparam logic [3:0] EJ_F2    = 4'b0001, EK_F2    = 4'b0000;
`endif

  jk_excite_gen #(.WIDTH(4), .SETTLE_CYC(1), .ERRW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .j_out    (j_out),
    .k_out    (k_out),
    .latch_en (latch_en),
    .q_fb     (q_fb),
    .done     (done),
    .mismatch (mismatch),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (latch_en) begin
      for (int i = 0; i < 4; i++) begin
        case ({j_out[i], k_out[i]})
          2'b01:   bank_q[i] <= 1'b0;
          2'b10:   bank_q[i] <= 1'b1;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end

  assign q_fb = stuck ? (bank_q & 4'b1110) : bank_q;

  // One full write; returns DRIVE-cycle outputs, CHECK-cycle outputs and done latency.
  task automatic do_write(input logic [3:0] d, output logic [3:0] jd, output logic [3:0] kd,
                          output logic le, output logic mm, output logic [7:0] ec, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL write_ready_timeout: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    jd  = j_out;
    kd  = k_out;
    le  = latch_en;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    mm = mismatch;
    ec = err_cnt;
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL write_done_timeout: done=%b required 1", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({j_out, k_out, latch_en, in_ready, done, mismatch, err_cnt} !== 20'h0) begin
      fails++;
      $display("FAIL reset_outputs: j=%b k=%b le=%b rdy=%b done=%b mm=%b err=%0d required all 0",
               j_out, k_out, latch_en, in_ready, done, mismatch, err_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({latch_en, j_out, k_out, in_ready} !== {1'b1, 4'b0000, 4'b1111, 1'b0}) begin
      fails++;
      $display("FAIL init_pulse: le=%b j=%b k=%b rdy=%b required le=1 j=0000 k=1111 rdy=0",
               latch_en, j_out, k_out, in_ready);
    end
    @(negedge clk);
    tests++;
    if ({latch_en, j_out, k_out, in_ready, err_cnt} !== {1'b0, 4'b0000, 4'b0000, 1'b1, 8'd0}) begin
      fails++;
      $display("FAIL init_to_idle: le=%b j=%b k=%b rdy=%b err=%0d required le=0 j=k=0 rdy=1 err=0",
               latch_en, j_out, k_out, in_ready, err_cnt);
    end
  endtask

  task automatic test_basic();
    logic [3:0] jd, kd;
    logic le, mm;
    logic [7:0] ec;
    int lat;
    do_write(4'b1010, jd, kd, le, mm, ec, lat);
    tests++;
    if ({jd, kd, le} !== {EJ_BASIC, EK_BASIC, 1'b1}) begin
      fails++;
      $display("FAIL basic_drive: j=%b k=%b le=%b required j=%b k=%b le=1", jd, kd, le, EJ_BASIC, EK_BASIC);
    end
    tests++;
    if (lat !== 3 || mm !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: latency=%0d mm=%b required latency=3 mm=0", lat, mm);
    end
    @(negedge clk);
    tests++;
    if ({in_ready, done, mismatch} !== 3'b100) begin
      fails++;
      $display("FAIL basic_return_idle: rdy=%b done=%b mm=%b required 1 0 0", in_ready, done, mismatch);
    end
  endtask

  task automatic test_mixed();
    logic [3:0] jd, kd;
    logic le, mm;
    logic [7:0] ec;
    int lat;
    do_write(4'b0110, jd, kd, le, mm, ec, lat);
    tests++;
    if ({jd, kd, le, mm} !== {EJ_MIXED, EK_MIXED, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL mixed_drive: j=%b k=%b le=%b mm=%b required j=%b k=%b le=1 mm=0",
               jd, kd, le, mm, EJ_MIXED, EK_MIXED);
    end
    do_write(4'b0110, jd, kd, le, mm, ec, lat);
    tests++;
    if ({jd, kd, le, mm, lat} !== {4'b0000, 4'b0000, 1'b1, 1'b0, 32'd3}) begin
      fails++;
      $display("FAIL same_value_write: j=%b k=%b le=%b mm=%b lat=%0d required j=k=0 le=1 mm=0 lat=3",
               jd, kd, le, mm, lat);
    end
  endtask

  task automatic test_fault();
    logic [3:0] jd, kd;
    logic le, mm;
    logic [7:0] ec;
    int lat;
    stuck = 1'b1;
    do_write(4'b0001, jd, kd, le, mm, ec, lat);
    tests++;
    if ({jd, kd, mm, ec} !== {EJ_F1, EK_F1, 1'b1, 8'd1}) begin
      fails++;
      $display("FAIL fault_first: j=%b k=%b mm=%b err=%0d required j=%b k=%b mm=1 err=1",
               jd, kd, mm, ec, EJ_F1, EK_F1);
    end
    do_write(4'b0001, jd, kd, le, mm, ec, lat);
    tests++;
    if ({jd, kd, mm, ec} !== {EJ_F2, EK_F2, 1'b1, 8'd2}) begin
      fails++;
      $display("FAIL fault_shadow_resync: j=%b k=%b mm=%b err=%0d required j=%b k=%b mm=1 err=2",
               jd, kd, mm, ec, EJ_F2, EK_F2);
    end
    for (int i = 0; i < 253; i++) do_write(4'b0001, jd, kd, le, mm, ec, lat);
    tests++;
    if (ec !== 8'd255) begin
      fails++;
      $display("FAIL err_reach_max: err=%0d required 255", ec);
    end
    for (int i = 0; i < 45; i++) do_write(4'b0001, jd, kd, le, mm, ec, lat);
    tests++;
    if (ec !== 8'd255 || mm !== 1'b1) begin
      fails++;
      $display("FAIL err_saturate: err=%0d mm=%b required 255 1", ec, mm);
    end
    stuck = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int n;
    @(negedge clk);
    in_data  = 4'b0001;
    in_valid = 1'b1;
    for (int i = 0; i < 26; i++) begin
      if (in_valid && in_ready) acc.push_back(cyc);
      @(negedge clk);
    end
    tests++;
    if (acc.size() < 5) begin
      fails++;
      $display("FAIL b2b_count: acceptances=%0d required >=5", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      tests++;
      if (acc[i] - acc[i-1] !== 4) begin
        fails++;
        $display("FAIL b2b_spacing: gap=%0d required 4", acc[i] - acc[i-1]);
      end
    end
    n = 0;
    while (!latch_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (latch_en !== 1'b1) begin
      fails++;
      $display("FAIL midwrite_find_drive: le=%b required 1", latch_en);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({j_out, k_out, latch_en, in_ready, done, mismatch, err_cnt} !== 20'h0) begin
      fails++;
      $display("FAIL midwrite_reset: j=%b k=%b le=%b rdy=%b done=%b mm=%b err=%0d required all 0",
               j_out, k_out, latch_en, in_ready, done, mismatch, err_cnt);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL midwrite_no_done: done=%b required 0", done);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({latch_en, j_out, k_out, in_ready} !== {1'b1, 4'b0000, 4'b1111, 1'b0}) begin
      fails++;
      $display("FAIL init_replay: le=%b j=%b k=%b rdy=%b required le=1 j=0000 k=1111 rdy=0",
               latch_en, j_out, k_out, in_ready);
    end
    @(negedge clk);
    tests++;
    if ({in_ready, err_cnt} !== {1'b1, 8'd0}) begin
      fails++;
      $display("FAIL replay_idle: rdy=%b err=%0d required rdy=1 err=0", in_ready, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mixed();
    test_fault();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
